// File: rtl/sobel_window_buffer_if.sv
// Pixel-in / window-out bundle for the Sobel 3x3 neighbourhood generator.
// The master drives frame control and pixels. The slave (the window buffer)
// returns the packed window and its status strobes.
interface sobel_window_buffer_if #(
    parameter int PIXEL_WIDTH = 8
);
    logic                     start_i;
    logic                     px_rdy_i;
    logic [PIXEL_WIDTH-1:0]   px_i;
    logic [9*PIXEL_WIDTH-1:0] window_o;
    logic                     window_rdy_o;
    logic                     frame_done_o;
    logic                     busy_o;

    modport master (
        output start_i, px_rdy_i, px_i,
        input  window_o, window_rdy_o, frame_done_o, busy_o
    );

    modport slave (
        input  start_i, px_rdy_i, px_i,
        output window_o, window_rdy_o, frame_done_o, busy_o
    );
endinterface

// File: rtl/sobel_window_buffer.sv
// Streaming 3x3 window generator feeding the Sobel kernel.
// Two line buffers hold the previous two rows. A 3x3 register window shifts
// left on every accepted pixel. A window is flagged valid only for interior
// centres, so border and stale line-buffer data never reach the output.
module sobel_window_buffer #(
    parameter int PIXEL_WIDTH = 8,
    parameter int IMG_WIDTH   = 16,
    parameter int IMG_HEIGHT  = 16
) (
    input  logic                  clk,
    input  logic                  nreset_i,
    sobel_window_buffer_if.slave  bus
);
    localparam int COL_W = $clog2(IMG_WIDTH);
    localparam int ROW_W = $clog2(IMG_HEIGHT);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);
    localparam logic [COL_W-1:0] COL_TWO  = COL_W'(2);
    localparam logic [ROW_W-1:0] ROW_TWO  = ROW_W'(2);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    state_t                   state_r;
    state_t                   state_s;
    logic [COL_W-1:0]         col_r;
    logic [ROW_W-1:0]         row_r;
    logic [9*PIXEL_WIDTH-1:0] window_r;
    logic                     window_rdy_r;
    logic                     frame_done_r;
    logic [PIXEL_WIDTH-1:0]   line0_r [IMG_WIDTH];
    logic [PIXEL_WIDTH-1:0]   line1_r [IMG_WIDTH];

    logic                     accept_s;
    logic                     col_end_s;
    logic                     last_px_s;
    logic                     win_valid_s;

    // Pixel acceptance and raster-position decode.
    always_comb begin
        accept_s  = 1'b0;
        col_end_s = (col_r == COL_LAST);
        if ((state_r == ST_ACTIVE) && bus.px_rdy_i && !bus.start_i) begin
            accept_s = 1'b1;
        end else begin
            accept_s = 1'b0;
        end
        last_px_s = accept_s && col_end_s && (row_r == ROW_LAST);
    end

    // State register.
    always_ff @(posedge clk or negedge nreset_i) begin
        if (!nreset_i) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic: start (re)opens a frame, the last pixel closes it.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.start_i) begin
                    state_s = ST_ACTIVE;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ACTIVE: begin
                if (bus.start_i) begin
                    state_s = ST_ACTIVE;
                end else if (last_px_s) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_ACTIVE;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Output decode: a window is valid once two full rows and two columns
    // of the current row are behind the incoming pixel.
    always_comb begin
        win_valid_s = 1'b0;
        if (accept_s && (row_r >= ROW_TWO) && (col_r >= COL_TWO)) begin
            win_valid_s = 1'b1;
        end else begin
            win_valid_s = 1'b0;
        end
    end

    // Raster counters; cleared on start and after the last pixel of a frame.
    always_ff @(posedge clk or negedge nreset_i) begin
        if (!nreset_i) begin
            col_r <= '0;
            row_r <= '0;
        end else if (bus.start_i) begin
            col_r <= '0;
            row_r <= '0;
        end else if (accept_s) begin
            if (last_px_s) begin
                col_r <= '0;
                row_r <= '0;
            end else if (col_end_s) begin
                col_r <= '0;
                row_r <= row_r + ROW_W'(1);
            end else begin
                col_r <= col_r + COL_W'(1);
            end
        end else begin
            col_r <= col_r;
            row_r <= row_r;
        end
    end

    // 3x3 window: shift columns left, load the new right column from the
    // two line buffers (top, middle) and the incoming pixel (bottom).
    always_ff @(posedge clk or negedge nreset_i) begin
        if (!nreset_i) begin
            window_r <= '0;
        end else if (accept_s) begin
            for (int r = 0; r < 3; r++) begin
                window_r[PIXEL_WIDTH*(3*r+0) +: PIXEL_WIDTH] <= window_r[PIXEL_WIDTH*(3*r+1) +: PIXEL_WIDTH];
                window_r[PIXEL_WIDTH*(3*r+1) +: PIXEL_WIDTH] <= window_r[PIXEL_WIDTH*(3*r+2) +: PIXEL_WIDTH];
            end
            window_r[PIXEL_WIDTH*2 +: PIXEL_WIDTH] <= line1_r[col_r];
            window_r[PIXEL_WIDTH*5 +: PIXEL_WIDTH] <= line0_r[col_r];
            window_r[PIXEL_WIDTH*8 +: PIXEL_WIDTH] <= bus.px_i;
        end else begin
            window_r <= window_r;
        end
    end

    // Line buffers age one row per accepted pixel; contents need no reset.
    always_ff @(posedge clk) begin
        if (accept_s) begin
            line1_r[col_r] <= line0_r[col_r];
            line0_r[col_r] <= bus.px_i;
        end
    end

    // Registered strobes: one-cycle pulses aligned with the updated window.
    always_ff @(posedge clk or negedge nreset_i) begin
        if (!nreset_i) begin
            window_rdy_r <= 1'b0;
            frame_done_r <= 1'b0;
        end else begin
            window_rdy_r <= win_valid_s;
            frame_done_r <= last_px_s;
        end
    end

    assign bus.window_o     = window_r;
    assign bus.window_rdy_o = window_rdy_r;
    assign bus.frame_done_o = frame_done_r;
    assign bus.busy_o       = (state_r == ST_ACTIVE);

endmodule

// File: tb/tb_sobel_window_buffer.sv
// Bench for sobel_window_buffer: a 4x4 instance driven from a vector table
// and hand sequences, and a 16x16 instance checked against an image model.
module tb_sobel_window_buffer;
    logic clk;
    logic nreset_i;
    int   n_vec;
    int   n_miss;

    sobel_window_buffer_if #(.PIXEL_WIDTH(8)) sif ();
    sobel_window_buffer_if #(.PIXEL_WIDTH(8)) bif ();

    sobel_window_buffer #(.PIXEL_WIDTH(8), .IMG_WIDTH(4), .IMG_HEIGHT(4)) dut_small (
        .clk      (clk),
        .nreset_i (nreset_i),
        .bus      (sif.slave)
    );

    sobel_window_buffer #(.PIXEL_WIDTH(8), .IMG_WIDTH(16), .IMG_HEIGHT(16)) dut_big (
        .clk      (clk),
        .nreset_i (nreset_i),
        .bus      (bif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        start;
        logic        px_rdy;
        logic [7:0]  px;
        logic        exp_rdy;
        logic        exp_done;
        logic        exp_busy;
        logic [71:0] exp_win;
    } vec_t;

    vec_t tbl [17];

    // big-frame model state
    logic [7:0] b_img [16][16];
    logic       b_active;
    int         b_k;
    int         b_win_cnt;
    int         b_done_cnt;

    task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [71:0] pack9(input int a0, input int a1, input int a2,
                                          input int a3, input int a4, input int a5,
                                          input int a6, input int a7, input int a8);
        logic [71:0] w;
        w = {a8[7:0], a7[7:0], a6[7:0], a5[7:0], a4[7:0], a3[7:0], a2[7:0], a1[7:0], a0[7:0]};
        return w;
    endfunction

    task automatic s_cycle(input logic st, input logic rdy, input logic [7:0] px);
        @(negedge clk);
        sif.start_i  = st;
        sif.px_rdy_i = rdy;
        sif.px_i     = px;
        @(posedge clk);
        #1;
    endtask

    task automatic s_idle_quiet(input string nm, input logic exp_busy);
        chk({nm, " rdy"},  {71'd0, sif.window_rdy_o}, 72'd0);
        chk({nm, " done"}, {71'd0, sif.frame_done_o}, 72'd0);
        chk({nm, " busy"}, {71'd0, sif.busy_o}, {71'd0, exp_busy});
    endtask

    task automatic apply_table(input int first, input int gap);
        for (int i = first; i < 17; i++) begin
            s_cycle(tbl[i].start, tbl[i].px_rdy, tbl[i].px);
            chk($sformatf("tbl%0d rdy", i),  {71'd0, sif.window_rdy_o}, {71'd0, tbl[i].exp_rdy});
            chk($sformatf("tbl%0d done", i), {71'd0, sif.frame_done_o}, {71'd0, tbl[i].exp_done});
            chk($sformatf("tbl%0d busy", i), {71'd0, sif.busy_o},       {71'd0, tbl[i].exp_busy});
            if (tbl[i].exp_rdy) chk($sformatf("tbl%0d win", i), sif.window_o, tbl[i].exp_win);
            for (int g = 0; g < gap; g++) begin
                s_cycle(1'b0, 1'b0, 8'd0);
                s_idle_quiet($sformatf("gap%0d_%0d", i, g), tbl[i].exp_busy);
                if (tbl[i].exp_rdy) chk($sformatf("gap%0d_%0d win", i, g), sif.window_o, tbl[i].exp_win);
            end
        end
        s_cycle(1'b0, 1'b0, 8'd0);
    endtask

    task automatic big_step(input logic st, input logic rdy, input logic [7:0] px);
        logic        e_rdy;
        logic        e_done;
        logic [71:0] e_win;
        int          r;
        int          c;
        e_rdy  = 1'b0;
        e_done = 1'b0;
        e_win  = '0;
        if (st) begin
            b_active = 1'b1;
            b_k      = 0;
        end else if (b_active && rdy) begin
            r = b_k / 16;
            c = b_k % 16;
            b_img[r][c] = px;
            if (r >= 2 && c >= 2) begin
                e_rdy = 1'b1;
                for (int i = 0; i < 3; i++)
                    for (int j = 0; j < 3; j++)
                        e_win[8*(3*i+j) +: 8] = b_img[r-2+i][c-2+j];
            end
            if (b_k == 255) begin
                e_done   = 1'b1;
                b_active = 1'b0;
            end
            b_k++;
        end
        @(negedge clk);
        bif.start_i  = st;
        bif.px_rdy_i = rdy;
        bif.px_i     = px;
        @(posedge clk);
        #1;
        b_win_cnt  += int'(bif.window_rdy_o);
        b_done_cnt += int'(bif.frame_done_o);
        chk($sformatf("big k%0d rdy", b_k),  {71'd0, bif.window_rdy_o}, {71'd0, e_rdy});
        chk($sformatf("big k%0d done", b_k), {71'd0, bif.frame_done_o}, {71'd0, e_done});
        chk($sformatf("big k%0d busy", b_k), {71'd0, bif.busy_o},       {71'd0, b_active});
        if (e_rdy) chk($sformatf("big k%0d win", b_k), bif.window_o, e_win);
    endtask

    initial begin
        n_vec  = 0;
        n_miss = 0;
        sif.start_i = 1'b0; sif.px_rdy_i = 1'b0; sif.px_i = 8'd0;
        bif.start_i = 1'b0; bif.px_rdy_i = 1'b0; bif.px_i = 8'd0;
        b_active = 1'b0; b_k = 0; b_win_cnt = 0; b_done_cnt = 0;

        // 4x4 frame, pixel value = raster index
        tbl[0] = '{1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 72'd0};
        for (int k = 0; k < 16; k++) begin
            tbl[k+1].start    = 1'b0;
            tbl[k+1].px_rdy   = 1'b1;
            tbl[k+1].px       = 8'(k);
            tbl[k+1].exp_rdy  = (k == 10 || k == 11 || k == 14 || k == 15);
            tbl[k+1].exp_done = (k == 15);
            tbl[k+1].exp_busy = (k != 15);
            tbl[k+1].exp_win  = 72'd0;
        end
        tbl[11].exp_win = pack9(0, 1, 2, 4, 5, 6, 8, 9, 10);
        tbl[12].exp_win = pack9(1, 2, 3, 5, 6, 7, 9, 10, 11);
        tbl[15].exp_win = pack9(4, 5, 6, 8, 9, 10, 12, 13, 14);
        tbl[16].exp_win = pack9(5, 6, 7, 9, 10, 11, 13, 14, 15);

        // reset state
        nreset_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        s_idle_quiet("reset", 1'b0);
        chk("reset win", sif.window_o, 72'd0);
        chk("reset big busy", {71'd0, bif.busy_o}, 72'd0);
        @(negedge clk);
        nreset_i = 1'b1;

        // 1: basic frame
        apply_table(0, 0);
        // 2: spaced input
        apply_table(0, 2);

        // 3: idle strobes ignored, then a proper frame
        for (int i = 0; i < 3; i++) begin
            s_cycle(1'b0, 1'b1, 8'(50 + i));
            s_idle_quiet($sformatf("idle%0d", i), 1'b0);
        end
        apply_table(0, 0);

        // 4: restart coinciding with a pixel
        s_cycle(1'b1, 1'b0, 8'd0);
        for (int k = 0; k < 7; k++) s_cycle(1'b0, 1'b1, 8'(k));
        s_cycle(1'b1, 1'b1, 8'd7);
        s_idle_quiet("restart", 1'b1);
        apply_table(1, 0);

        // 5: async reset mid-frame
        s_cycle(1'b1, 1'b0, 8'd0);
        for (int k = 0; k < 10; k++) s_cycle(1'b0, 1'b1, 8'(k));
        s_cycle(1'b0, 1'b0, 8'd0);
        #2;
        nreset_i = 1'b0;
        #1;
        s_idle_quiet("async rst", 1'b0);
        chk("async rst win", sif.window_o, 72'd0);
        @(negedge clk);
        nreset_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            s_cycle(1'b0, 1'b1, 8'(i));
            s_idle_quiet($sformatf("post rst%0d", i), 1'b0);
            chk($sformatf("post rst%0d win", i), sif.window_o, 72'd0);
        end
        apply_table(0, 0);

        // 6: 16x16 random frame against the image model
        big_step(1'b1, 1'b0, 8'd0);
        for (int k = 0; k < 256; k++) begin
            big_step(1'b0, 1'b1, 8'($urandom_range(0, 255)));
            repeat ($urandom_range(0, 2)) big_step(1'b0, 1'b0, 8'($urandom_range(0, 255)));
        end
        big_step(1'b0, 1'b0, 8'd0);
        chk("big window count", 72'(b_win_cnt), 72'd196);
        chk("big done count",   72'(b_done_cnt), 72'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
